// File: rtl/rf_pkg.sv
// Shared definitions for the banked register file: copy-FSM encoding and default geometry.
package rf_pkg;

  // Default datapath geometry, shared with the surrounding datapath.
  localparam int unsigned RF_WIDTH = 8;
  localparam int unsigned RF_NREGS = 16;

  // Copy-engine state encoding.
  typedef enum logic [1:0] {
    RF_IDLE    = 2'd0,
    RF_SAVE    = 2'd1,
    RF_RESTORE = 2'd2
  } rf_state_e;

endpackage : rf_pkg

// File: rtl/rf_copy_fsm.sv
// Sequencer for bank copies: walks idx from 1 to NREGS-1, one register per cycle.
module rf_copy_fsm
  import rf_pkg::*;
#(
  parameter int unsigned NREGS = RF_NREGS,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          save,
  input  logic          restore,
  output logic [1:0]    state,
  output logic [AW-1:0] idx,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
  localparam logic          ONE_COPY = (NREGS == 2);

  rf_state_e     state_q;
  logic [AW-1:0] idx_q;
  logic          busy_q;
  logic          done_q;

  // State, index and status flags; requests are only sampled in IDLE, save has priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RF_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        RF_IDLE: begin
          if (save || restore) begin
            state_q <= save ? RF_SAVE : RF_RESTORE;
            idx_q   <= AW'(1);
            busy_q  <= 1'b1;
            done_q  <= ONE_COPY;
          end
        end
        RF_SAVE, RF_RESTORE: begin
          if (idx_q == LAST_IDX) begin
            state_q <= RF_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            idx_q  <= idx_q + AW'(1);
            done_q <= ((idx_q + AW'(1)) == LAST_IDX);
          end
        end
        default: begin
          state_q <= RF_IDLE;
          idx_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign state = state_q;
  assign idx   = idx_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule : rf_copy_fsm

// File: rtl/regfile_banked.sv
// Register file with two combinational read ports, one write port, r0 hard-wired to zero,
// and a shadow bank filled/drained by a one-register-per-cycle copy engine.
module regfile_banked
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH  = RF_WIDTH,
  parameter int unsigned NREGS  = RF_NREGS,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we3,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             save,
  input  logic             restore,
  output logic             busy,
  output logic             done
);

  localparam logic BYP_EN = (BYPASS != 0);

  logic [WIDTH-1:0] regs_q   [NREGS];
  logic [WIDTH-1:0] shadow_q [NREGS];

  logic [1:0]    cp_state;
  logic [AW-1:0] cp_idx;
  logic          port_wr;
  logic          copy_save;
  logic          copy_restore;

  rf_copy_fsm #(
    .NREGS (NREGS)
  ) u_copy_fsm (
    .clk     (clk),
    .reset   (reset),
    .save    (save),
    .restore (restore),
    .state   (cp_state),
    .idx     (cp_idx),
    .busy    (busy),
    .done    (done)
  );

  assign port_wr      = we3 && (wa3 != '0);
  assign copy_save    = (cp_state == RF_SAVE);
  assign copy_restore = (cp_state == RF_RESTORE);

  // Live bank: the port write is issued last so it overrides a restore to the same index.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      if (copy_restore) regs_q[cp_idx] <= shadow_q[cp_idx];
      if (port_wr)      regs_q[wa3]    <= wd3;
    end
  end

  // Shadow bank: captures the pre-edge live value, so a same-edge port write is not seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) shadow_q[i] <= '0;
    end else if (copy_save) begin
      shadow_q[cp_idx] <= regs_q[cp_idx];
    end
  end

  // Read ports: r0 reads zero, optional same-cycle forwarding of the write port.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) rd1 = (BYP_EN && we3 && (wa3 == ra1)) ? wd3 : regs_q[ra1];
    if (ra2 != '0) rd2 = (BYP_EN && we3 && (wa3 == ra2)) ? wd3 : regs_q[ra2];
  end

endmodule : regfile_banked
